// File: rtl/r_alu_share_arb.sv
// r_alu_share_arb: round-robin arbiter for one shared R-type ALU
// with a one-entry tagged response buffer.
module r_alu_share_arb #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [4:0]      req_func0,
  input  logic [4:0]      req_func1,
  input  logic [XLEN-1:0] req_rs1_0,
  input  logic [XLEN-1:0] req_rs1_1,
  input  logic [XLEN-1:0] req_rs2_0,
  input  logic [XLEN-1:0] req_rs2_1,
  input  logic [TAGW-1:0] req_rd0,
  input  logic [TAGW-1:0] req_rd1,
  output logic [4:0]      alu_func,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [TAGW-1:0] resp_rd,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err
);

  logic            resp_valid_q, resp_valid_d;
  logic            resp_id_q, resp_id_d;
  logic [TAGW-1:0] resp_rd_q, resp_rd_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;
  logic            last_grant_q, last_grant_d;

  logic            any_req;
  logic            gnt;
  logic            can_accept;
  logic            accept;
  logic            legal;
  logic [TAGW-1:0] gnt_rd;

  // Only the ten RV32I R-type codes are executable.
  function automatic logic is_legal(input logic [4:0] f);
    case (f)
      5'b00000, 5'b10000, 5'b00001,
      5'b00010, 5'b00011, 5'b00100,
      5'b00101, 5'b10101, 5'b00110,
      5'b00111: is_legal = 1'b1;
      default:  is_legal = 1'b0;
    endcase
  endfunction

  // Round-robin grant and ALU operand steering.
  always_comb begin
    any_req = |req_valid;
    gnt     = 1'b0;
    unique case (1'b1)
      (req_valid == 2'b11): gnt = ~last_grant_q;
      (req_valid == 2'b10): gnt = 1'b1;
      default:              gnt = 1'b0;
    endcase
    can_accept = !flush && (!resp_valid_q || resp_ready);
    accept     = can_accept && any_req;
    req_ready  = {accept && gnt, accept && !gnt};
    alu_func   = gnt ? req_func1 : req_func0;
    alu_a      = gnt ? req_rs1_1 : req_rs1_0;
    alu_b      = gnt ? req_rs2_1 : req_rs2_0;
    gnt_rd     = gnt ? req_rd1 : req_rd0;
    legal      = is_legal(alu_func);
  end

  // Response buffer load, drain and flush.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_rd_d    = resp_rd_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_id_d    = gnt;
      resp_rd_d    = gnt_rd;
      resp_data_d  = legal ? alu_result : '0;
      resp_err_d   = !legal;
      last_grant_d = gnt;
    end else if (flush || resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_rd    = resp_rd_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_r_alu_share_arb.sv
// tb_r_alu_share_arb: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_r_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst, flush, resp_ready;
  logic [1:0]  req_valid, req_ready;
  logic [4:0]  req_func0, req_func1, alu_func;
  logic [31:0] req_rs1_0, req_rs1_1, req_rs2_0, req_rs2_1;
  logic [31:0] alu_a, alu_b, alu_result, resp_data;
  logic [4:0]  req_rd0, req_rd1, resp_rd;
  logic        resp_valid, resp_id, resp_err;

  int checks = 0;
  int errors = 0;

  logic        m_valid, m_id, m_err, m_last;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  logic [4:0] lg [10] = '{5'b00000, 5'b10000, 5'b00001, 5'b00010,
                          5'b00011, 5'b00100, 5'b00101, 5'b10101,
                          5'b00110, 5'b00111};

  always #5 clk = ~clk;

  r_alu_share_arb #(.XLEN(32), .TAGW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_func0(req_func0), .req_func1(req_func1),
    .req_rs1_0(req_rs1_0), .req_rs1_1(req_rs1_1),
    .req_rs2_0(req_rs2_0), .req_rs2_1(req_rs2_1),
    .req_rd0(req_rd0), .req_rd1(req_rd1),
    .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_rd(resp_rd),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  function automatic logic [31:0] ref_alu(
    input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = int'(b % 32);
    case (f)
      5'b00000: return a + b;
      5'b10000: return a - b;
      5'b00001: return a << sh;
      5'b00010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'b00011: return (a < b) ? 32'd1 : 32'd0;
      5'b00100: return a ^ b;
      5'b00101: return a >> sh;
      5'b10101: return 32'($signed(a) >>> sh);
      5'b00110: return a | b;
      5'b00111: return a & b;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic ref_legal(input logic [4:0] f);
    if (f[3]) return 1'b0;
    if (!f[4]) return 1'b1;
    return (f[2:0] == 3'd0) || (f[2:0] == 3'd5);
  endfunction

  always_comb alu_result = ref_alu(alu_func, alu_a, alu_b);

  // Requester the model would pick, ignoring backpressure.
  function automatic logic pick();
    if (req_valid == 2'b11) return !m_last;
    return req_valid[1];
  endfunction

  function automatic logic [1:0] exp_rdy();
    if (flush || (m_valid && !resp_ready)) return 2'b00;
    if (req_valid == 2'b00) return 2'b00;
    return pick() ? 2'b10 : 2'b01;
  endfunction

  task automatic tick();
    logic [1:0] r;
    logic       g;
    logic [4:0] f;
    r = exp_rdy();
    g = r[1];
    if (rst) begin
      m_valid = 0; m_id = 0; m_rd = 0;
      m_data = 0; m_err = 0; m_last = 1;
    end else if (r != 2'b00) begin
      f       = g ? req_func1 : req_func0;
      m_valid = 1;
      m_id    = g;
      m_rd    = g ? req_rd1 : req_rd0;
      m_err   = !ref_legal(f);
      m_data  = m_err ? 32'd0 :
        ref_alu(f, g ? req_rs1_1 : req_rs1_0, g ? req_rs2_1 : req_rs2_0);
      m_last  = g;
    end else if (flush || resp_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] f,
    input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    if (i == 0) begin
      req_func0 = f; req_rs1_0 = a; req_rs2_0 = b; req_rd0 = rd;
    end else begin
      req_func1 = f; req_rs1_1 = a; req_rs2_1 = b; req_rd1 = rd;
    end
  endtask

  function automatic logic [39:0] bundle();
    return {resp_valid, resp_id, resp_rd, resp_data, resp_err};
  endfunction

  task automatic test_reset();
    rst = 1; tick();
    checks++;
    if (bundle() !== 40'd0) begin
      errors++;
      $display("FAIL reset_resp got %h exp 0", bundle());
    end
    rst = 0;
  endtask

  task automatic test_single();
    set_req(0, 5'b00000, 32'd5, 32'd7, 5'd3);
    req_valid = 2'b01; resp_ready = 1; #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready got %b exp 01", req_ready);
    end
    tick();
    checks++;
    if (bundle() !== {1'b1, 1'b0, 5'd3, 32'd12, 1'b0}) begin
      errors++;
      $display("FAIL single_resp got %h", bundle());
    end
    req_valid = 2'b00; tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got %b exp 0", resp_valid);
    end
  endtask

  task automatic test_alternate();
    rst = 1; tick(); rst = 0;
    set_req(0, 5'b10000, 32'd10, 32'd3, 5'd1);
    set_req(1, 5'b10101, 32'h8000_0000, 32'd4, 5'd2);
    req_valid = 2'b11; resp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (req_ready !== ((k % 2) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL alt_ready k=%0d got %b", k, req_ready);
      end
      tick();
      checks++;
      if ((k % 2) == 0 &&
          bundle() !== {1'b1, 1'b0, 5'd1, 32'd7, 1'b0}) begin
        errors++;
        $display("FAIL alt_resp0 k=%0d got %h", k, bundle());
      end else if ((k % 2) == 1 &&
          bundle() !== {1'b1, 1'b1, 5'd2, 32'hF800_0000, 1'b0}) begin
        errors++;
        $display("FAIL alt_resp1 k=%0d got %h", k, bundle());
      end
    end
  endtask

  task automatic test_stall();
    resp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ready !== 2'b00) begin
        errors++;
        $display("FAIL stall_ready k=%0d got %b exp 00", k, req_ready);
      end
      tick();
      checks++;
      if (bundle() !== {1'b1, 1'b1, 5'd2, 32'hF800_0000, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold k=%0d got %h", k, bundle());
      end
    end
    resp_ready = 1; #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL stall_release got %b exp 01", req_ready);
    end
    tick();
    checks++;
    if (bundle() !== {1'b1, 1'b0, 5'd1, 32'd7, 1'b0}) begin
      errors++;
      $display("FAIL stall_next got %h", bundle());
    end
  endtask

  task automatic test_illegal();
    set_req(1, 5'b01000, 32'd2, 32'd3, 5'd9);
    req_valid = 2'b10; #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL ill_ready got %b exp 10", req_ready);
    end
    tick();
    checks++;
    if (bundle() !== {1'b1, 1'b1, 5'd9, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL ill_resp got %h", bundle());
    end
    req_valid = 2'b11; #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL ill_lastgrant got %b exp 01", req_ready);
    end
    tick();
  endtask

  task automatic test_flush();
    set_req(0, 5'b00000, 32'd5, 32'd7, 5'd3);
    req_valid = 2'b01; resp_ready = 1; tick();
    flush = 1; #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL flush_ready got %b exp 00", req_ready);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop got %b exp 0", resp_valid);
    end
    flush = 0; #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL flush_after got %b exp 01", req_ready);
    end
    tick();
    checks++;
    if (bundle() !== {1'b1, 1'b0, 5'd3, 32'd12, 1'b0}) begin
      errors++;
      $display("FAIL flush_resp got %h", bundle());
    end
  endtask

  task automatic test_reset_mid();
    set_req(1, 5'b00100, 32'hFF, 32'h0F, 5'd4);
    req_valid = 2'b10; tick();
    req_valid = 2'b11; rst = 1; tick();
    checks++;
    if (bundle() !== 40'd0) begin
      errors++;
      $display("FAIL rstmid_resp got %h exp 0", bundle());
    end
    rst = 0; #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_grant got %b exp 01", req_ready);
    end
    tick();
  endtask

  task automatic test_random();
    logic g;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++)
        set_req(i,
          ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                      : lg[$urandom_range(0, 9)],
          $urandom, $urandom, 5'($urandom));
      req_valid  = 2'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 9) == 0);
      rst        = ($urandom_range(0, 49) == 0);
      #1;
      checks++;
      if (req_ready !== exp_rdy()) begin
        errors++;
        $display("FAIL rnd_ready k=%0d got %b exp %b",
          k, req_ready, exp_rdy());
      end
      g = (req_valid != 2'b00) && pick();
      checks++;
      if ({alu_func, alu_a, alu_b} !==
          (g ? {req_func1, req_rs1_1, req_rs2_1}
             : {req_func0, req_rs1_0, req_rs2_0})) begin
        errors++;
        $display("FAIL rnd_alu k=%0d got %h %h %h",
          k, alu_func, alu_a, alu_b);
      end
      tick();
      checks++;
      if (bundle() !== {m_valid, m_id, m_rd, m_data, m_err}) begin
        errors++;
        $display("FAIL rnd_resp k=%0d got %h exp %h", k, bundle(),
          {m_valid, m_id, m_rd, m_data, m_err});
      end
    end
    rst = 0; flush = 0;
  endtask

  initial begin
    rst = 0; flush = 0; resp_ready = 0; req_valid = 2'b00;
    set_req(0, 5'd0, 32'd0, 32'd0, 5'd0);
    set_req(1, 5'd0, 32'd0, 32'd0, 5'd0);
    m_valid = 0; m_id = 0; m_rd = 0; m_data = 0; m_err = 0; m_last = 1;
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
